// File: rtl/mux_arb_nch.sv
// N-channel registered selector: arbitrates among valid/ready producers (fixed, round-robin
// or forced) and loads the winning word into a single output register.
module mux_arb_nch #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode,
   input  logic [SEL_W-1:0]     sel,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_sel,
   input  logic                 out_ready
);

   typedef enum logic [1:0] {
      MODE_FIXED  = 2'b00,
      MODE_RR     = 2'b01,
      MODE_FORCED = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   mode_e            mode_q;
   logic [SEL_W-1:0] rr_ptr;
   logic             load_en;
   logic             gnt_found;
   logic [SEL_W-1:0] gnt_idx;
   int unsigned      cand;
   logic [WIDTH-1:0] ch_data [NCH];

   assign mode_q  = mode_e'(mode);
   assign load_en = !out_valid | out_ready;

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         ch_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      unique case (mode_q)
         MODE_RR: begin
            // Walk the channels starting at rr_ptr, wrapping at NCH
            for (int unsigned k = 0; k < NCH; k++) begin
               cand = 32'(rr_ptr) + k;
               if (cand >= NCH) cand = cand - NCH;
               if (!gnt_found && in_valid[cand]) begin
                  gnt_found = 1'b1;
                  gnt_idx   = SEL_W'(cand);
               end
            end
         end
         MODE_FORCED: begin
            // An out-of-range sel matches no channel and so yields no grant
            for (int unsigned i = 0; i < NCH; i++) begin
               if (sel == SEL_W'(i) && in_valid[i]) begin
                  gnt_found = 1'b1;
                  gnt_idx   = SEL_W'(i);
               end
            end
         end
         default: begin
            for (int unsigned i = 0; i < NCH; i++) begin
               if (!gnt_found && in_valid[i]) begin
                  gnt_found = 1'b1;
                  gnt_idx   = SEL_W'(i);
               end
            end
         end
      endcase
   end

   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (gnt_found && gnt_idx == SEL_W'(i)) begin
            in_ready[i] = load_en & rst_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         out_valid <= gnt_found;
         if (gnt_found) begin
            out_data <= ch_data[gnt_idx];
            out_sel  <= gnt_idx;
            rr_ptr   <= (gnt_idx == SEL_W'(NCH-1)) ? '0 : gnt_idx + SEL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_nch.sv
// Self-checking bench for mux_arb_nch (NCH=4, WIDTH=8): directed scenarios plus random
// traffic, compared against a transaction-level model of the selector.
module tb_mux_arb_nch;

   localparam int NCH   = 4;
   localparam int WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [1:0]  sel = 2'b00;
   logic [3:0]  in_valid = 4'h0;
   logic [31:0] in_data = 32'h0;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready = 1'b0;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic        m_valid = 1'b0;
   logic [7:0]  m_data = 8'h0;
   int          m_sel = 0;
   int          m_ptr = 0;

   mux_arb_nch #(.NCH(NCH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [1:0] md, input logic [1:0] sl,
                               input logic [3:0] v, input int ptr);
      if (md == 2'b10) return v[sl] ? int'(sl) : -1;
      if (md == 2'b01) begin
         for (int k = 0; k < NCH; k++) begin
            if (v[(ptr + k) % NCH]) return (ptr + k) % NCH;
         end
         return -1;
      end
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
      return -1;
   endfunction

   // One cycle: drive inputs, check in_ready, clock, update model, check outputs.
   task automatic step(input logic rn, input logic [1:0] md, input logic [1:0] sl,
                       input logic [3:0] v, input logic [31:0] d, input logic ordy);
      int g;
      logic load;
      logic [3:0] exp_rdy;
      logic [7:0] word;
      @(negedge clk);
      rst_n = rn; mode = md; sel = sl; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      load = !m_valid || ordy;
      g = pick(md, sl, v, m_ptr);
      exp_rdy = (rn && load && g >= 0) ? 4'(1 << g) : 4'h0;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (!rn) begin
         m_valid = 1'b0; m_data = 8'h0; m_sel = 0; m_ptr = 0;
      end else if (load) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            word = d[g*8 +: 8];
            m_data = word; m_sel = g; m_ptr = (g + 1) % NCH;
         end
      end
      #1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_sel", 32'(out_sel), 32'(m_sel));
   endtask

   initial begin
      // Reset with all channels valid
      step(1'b0, 2'b00, 2'd0, 4'hF, 32'h44332211, 1'b1);
      step(1'b0, 2'b00, 2'd0, 4'hF, 32'h44332211, 1'b1);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      step(1'b1, 2'b00, 2'd0, 4'hF, 32'h44332211, 1'b1);
      check("first_word", 32'({out_valid, out_data}), 32'h111);

      // Fixed priority with channels 1 and 3 valid
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 2'b00, 2'd0, 4'b1010, 32'($urandom), 1'b1);
         check("fixed_sel", 32'(out_sel), 32'd1);
         check("fixed_ch3_rdy", 32'(in_ready[3]), 32'h0);
      end

      // Round-robin from a freshly reset pointer
      step(1'b0, 2'b01, 2'd0, 4'hF, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 2'b01, 2'd0, 4'hF, 32'($urandom), 1'b1);
         check("rr_seq", 32'(out_sel), 32'(i % NCH));
         check("rr_nobubble", 32'(out_valid), 32'h1);
      end

      // Forced select
      step(1'b1, 2'b10, 2'd2, 4'b1011, 32'($urandom), 1'b1);
      check("forced_drop", 32'(out_valid), 32'h0);
      step(1'b1, 2'b10, 2'd2, 4'b0100, 32'h00A50000, 1'b1);
      check("forced_word", 32'({out_sel, out_data}), 32'h2A5);

      // Back-pressure for 3 cycles, then release
      step(1'b1, 2'b00, 2'd0, 4'b0001, 32'h0000003C, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b00, 2'd0, 4'hF, 32'($urandom), 1'b0);
         check("bp_data", 32'({out_sel, out_data}), 32'h03C);
         check("bp_ready", 32'(in_ready), 32'h0);
      end
      step(1'b1, 2'b00, 2'd0, 4'b0100, 32'h00770000, 1'b1);
      check("bp_release", 32'({out_valid, out_sel, out_data}), 32'h677);

      // Reset while a word is held under back-pressure
      step(1'b1, 2'b01, 2'd0, 4'hF, 32'($urandom), 1'b1);
      step(1'b1, 2'b01, 2'd0, 4'hF, 32'($urandom), 1'b0);
      step(1'b0, 2'b01, 2'd0, 4'hF, 32'($urandom), 1'b0);
      check("midrst_drop", 32'(out_valid), 32'h0);
      step(1'b1, 2'b01, 2'd0, 4'hF, 32'($urandom), 1'b1);
      check("midrst_ch0", 32'({out_valid, out_sel}), 32'h4);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) != 0), 2'($urandom), 2'($urandom),
              4'($urandom), 32'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
